mem_stage: RTL

- Memory-access stage directly downstream of the execute stage; consumes the execute result (ALU result / effective address) plus load/store control.
- Issues at most one data-memory transaction at a time over a req/gnt/rvalid bus and presents a registered result to writeback under a valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
//
// Accepts one instruction at a time from execute. Non-memory results pass
// straight to the output register. Aligned loads and stores perform a single
// transaction on a req/gnt/rvalid data bus. Misaligned accesses are flagged
// without touching the bus. The result is presented to writeback under a
// valid/ready handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ex_*                execute-side handshake and instruction fields
//   dmem_*              data memory bus (one outstanding access)
//   wb_*                writeback-side handshake and result fields
module mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  // execute side
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_inst_type_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic [4:0]      ex_mem_op_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rd_wena_i,
  // data memory bus
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wstrb_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  // writeback side
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_inst_type_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic            wb_rd_wena_o,
  output logic [XLEN-1:0] wb_rd_data_o,
  output logic            wb_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, OUT} state_e;

  state_e            state_q, state_d;
  logic [4:0]        inst_type_q, inst_type_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [4:0]        mem_op_q, mem_op_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              rd_wena_q, rd_wena_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              misalign_q, misalign_d;

  logic              accept;
  logic              ex_misalign;
  logic              is_store_q;
  logic [7:0]        size_mask;
  logic [XLEN-1:0]   rdata_shifted;
  logic [XLEN-1:0]   load_data;

  assign ex_ready_o = (state_q == IDLE) | ((state_q == OUT) & wb_ready_i);
  assign accept     = ex_valid_i & ex_ready_o;
  assign is_store_q = mem_op_q[3];

  // Alignment is judged on the incoming address so the decision is made
  // on the accept edge.
  always_comb begin
    ex_misalign = 1'b0;
    case (ex_mem_op_i[1:0])
      2'b00:   ex_misalign = 1'b0;
      2'b01:   ex_misalign = ex_result_i[0];
      2'b10:   ex_misalign = |ex_result_i[1:0];
      default: ex_misalign = |ex_result_i[2:0];
    endcase
  end

  always_comb begin
    size_mask = 8'h00;
    case (mem_op_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Bring the addressed byte lane down to bit 0, then sign/zero-extend.
  // Doubleword loads take the whole word and ignore the unsigned bit.
  assign rdata_shifted = dmem_rdata_i >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    case (mem_op_q[1:0])
      2'b00: load_data = mem_op_q[2] ? {{(XLEN-8){1'b0}}, rdata_shifted[7:0]}
                                     : {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01: load_data = mem_op_q[2] ? {{(XLEN-16){1'b0}}, rdata_shifted[15:0]}
                                     : {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      2'b10: load_data = mem_op_q[2] ? {{(XLEN-32){1'b0}}, rdata_shifted[31:0]}
                                     : {{(XLEN-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // Next-state logic. The accept capture is placed last so that a
  // back-to-back accept in OUT overrides the return to IDLE.
  always_comb begin
    state_d     = state_q;
    inst_type_d = inst_type_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    mem_op_d    = mem_op_q;
    rd_addr_d   = rd_addr_q;
    rd_wena_d   = rd_wena_q;
    rd_data_d   = rd_data_q;
    misalign_d  = misalign_q;

    case (state_q)
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = is_store_q ? OUT : RSP;
        end
      end
      // RSP is only entered on the edge after gnt, so an rvalid coincident
      // with gnt is never seen here.
      RSP: begin
        if (dmem_rvalid_i) begin
          rd_data_d = load_data;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (wb_ready_i) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      inst_type_d = ex_inst_type_i;
      addr_d      = ex_result_i;
      sdata_d     = ex_store_data_i;
      mem_op_d    = ex_mem_op_i;
      rd_addr_d   = ex_rd_addr_i;
      if (!ex_mem_op_i[4]) begin
        rd_wena_d  = ex_rd_wena_i;
        rd_data_d  = ex_result_i;
        misalign_d = 1'b0;
        state_d    = OUT;
      end else if (ex_misalign) begin
        rd_wena_d  = 1'b0;
        rd_data_d  = '0;
        misalign_d = 1'b1;
        state_d    = OUT;
      end else begin
        rd_wena_d  = ex_mem_op_i[3] ? 1'b0 : ex_rd_wena_i;
        rd_data_d  = '0;
        misalign_d = 1'b0;
        state_d    = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      inst_type_q <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      mem_op_q    <= '0;
      rd_addr_q   <= '0;
      rd_wena_q   <= 1'b0;
      rd_data_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_type_q <= inst_type_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      mem_op_q    <= mem_op_d;
      rd_addr_q   <= rd_addr_d;
      rd_wena_q   <= rd_wena_d;
      rd_data_q   <= rd_data_d;
      misalign_q  <= misalign_d;
    end
  end

  // Bus outputs are decoded from state so they drop as soon as reset
  // clears the state register.
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = (state_q == REQ) & is_store_q;
  assign dmem_addr_o  = (state_q == REQ) ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign dmem_wstrb_o = ((state_q == REQ) && is_store_q) ? (size_mask << addr_q[2:0]) : 8'h00;
  assign dmem_wdata_o = ((state_q == REQ) && is_store_q) ? (sdata_q << {addr_q[2:0], 3'b000}) : '0;

  assign wb_valid_o     = (state_q == OUT);
  assign wb_inst_type_o = inst_type_q;
  assign wb_rd_addr_o   = rd_addr_q;
  assign wb_rd_wena_o   = rd_wena_q;
  assign wb_rd_data_o   = rd_data_q;
  assign wb_misalign_o  = misalign_q;

endmodule
